mem_dump_arbiter: RTL
=====================

// Module: mem_dump_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage and the debug unit.
//  On request it sequences a full memory dump (addr 0..2^MEM_SZ-1), one word per handshake, to the debugger.
//  The pipeline always has priority. The dump only uses cycles in which the MEM stage neither reads nor writes.
//  Sits between the MEM stage control/address lines and the data_mem instance.
// PARAMETERS
//  INST_SZ  32  data word width (bits)
//  MEM_SZ   5   address width; memory depth = 2^MEM_SZ words
// PORTS
//  i_clk          in   1        clock; all state updates on rising edge
//  i_reset        in   1        asynchronous, active-low reset
//  i_mem_read_M   in   1        MEM-stage MemRead
//  i_mem_write_M  in   1        MEM-stage MemWrite
//  i_addr_M       in   MEM_SZ   MEM-stage word address
//  i_wdata_M      in   INST_SZ  MEM-stage write data
//  o_mem_read     out  1        to data_mem MemRead
//  o_mem_write    out  1        to data_mem MemWrite
//  o_mem_addr     out  MEM_SZ   to data_mem address
//  o_mem_wdata    out  INST_SZ  to data_mem write data
//  i_mem_rdata    in   INST_SZ  from data_mem; valid 1 cycle after o_mem_read (synchronous read)
//  i_dump_start   in   1        debugger request; sampled only in IDLE
//  i_dump_ready   in   1        debugger accepts current word
//  o_dump_valid   out  1        o_dump_data/o_dump_addr hold a valid word
//  o_dump_data    out  INST_SZ  dumped word
//  o_dump_addr    out  MEM_SZ   address of o_dump_data
//  o_dump_busy    out  1        high from the cycle after start is accepted until DONE ends
//  o_dump_done    out  1        one-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Reset (i_reset=0, async):
//   - state=IDLE; internal address counter=0.
//   - o_dump_valid/o_dump_busy/o_dump_done=0; o_dump_data=0; o_dump_addr=0.
//   - Pipeline passthrough to the memory port stays active.
//  Port mux (combinational):
//   - pipe_act = i_mem_read_M | i_mem_write_M.
//   - If pipe_act: o_mem_* = pipeline signals.
//   - Else if state==ISSUE: o_mem_read=1, o_mem_write=0, o_mem_addr=cnt.
//   - Else: o_mem_read=0, o_mem_write=0, o_mem_addr=i_addr_M.
//   - o_mem_wdata = i_wdata_M in all cases.
//   - The dump never writes memory.
//  FSM:
//   IDLE:    busy=0. If i_dump_start: cnt<=0, go to ISSUE.
//   ISSUE:   busy=1. If pipe_act: stay; the pipeline owns the port and no dump read is issued.
//            Else: dump read issued this cycle; go to CAPTURE.
//   CAPTURE: o_dump_data<=i_mem_rdata, o_dump_addr<=cnt, o_dump_valid<=1; go to HOLD.
//            Pipeline access in this cycle is legal and does not affect the captured word.
//   HOLD:    valid=1; data and addr held stable.
//            On valid&ready: valid<=0.
//            If cnt==2^MEM_SZ-1: go to DONE. Else: cnt<=cnt+1, go to ISSUE.
//   DONE:    o_dump_done=1 for exactly one cycle; busy=1; then go to IDLE.
//  Timing and limits:
//   - Minimum 3 cycles per word: ISSUE, CAPTURE, HOLD with ready=1.
//   - cnt is MEM_SZ bits and never wraps past the last address.
//   - i_dump_start in any state other than IDLE is ignored.
//   - Simultaneous pipe_act and ISSUE: the pipeline wins; the dump retries every cycle (no starvation counter).
//   - A pipeline write landing before the dump reads that address is reflected in the dump.
//     The dump is not a snapshot.
//   - Reset mid-dump aborts without a done pulse. The next start restarts at address 0.
// TESTING
//  1. Preload mem[i]=0xA0+i, ready=1, pipeline idle, pulse start
//     -> 32 beats, addr 0..31, data 0xA0..0xBF, one beat every 3 cycles.
//     -> done pulses 1 cycle after the beat at addr 31; busy=0 the cycle after that.
//  2. During ISSUE at addr 4, hold i_mem_read_M=1, i_addr_M=9 for 10 cycles
//     -> o_mem_addr=9 and no dump read during those cycles.
//     -> The dump read of addr 4 is issued in the first cycle after release.
//  3. Hold ready=0 for 5 cycles at addr 2
//     -> valid=1, data=0xA2, addr=2 stable; the addr 3 read starts after the handshake.
//  4. Pulse start at addr 10 and again in the DONE cycle
//     -> both ignored: a single 32-beat sequence and a single done pulse.
//  5. Assert i_reset=0 mid-dump at addr 7
//     -> all dump outputs 0 immediately, with no done pulse.
//     -> A new start begins again at addr 0.
//  6. At addr 3, pipeline writes mem[5]=0xDEAD
//     -> the beat at addr 5 carries 0xDEAD, and mem[5] holds 0xDEAD.

Source files
------------

// File: rtl/mem_dump_arbiter.sv
// Arbitrates the single-port data memory between the pipeline MEM stage and a debug dump sequencer.
// The pipeline always wins the port. The dump walks addresses 0..2^MEM_SZ-1 using only idle memory cycles.
module mem_dump_arbiter #(
  parameter int INST_SZ = 32,
  parameter int MEM_SZ  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_mem_read_M,
  input  logic               i_mem_write_M,
  input  logic [MEM_SZ-1:0]  i_addr_M,
  input  logic [INST_SZ-1:0] i_wdata_M,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic [MEM_SZ-1:0]  o_mem_addr,
  output logic [INST_SZ-1:0] o_mem_wdata,
  input  logic [INST_SZ-1:0] i_mem_rdata,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic               o_dump_valid,
  output logic [INST_SZ-1:0] o_dump_data,
  output logic [MEM_SZ-1:0]  o_dump_addr,
  output logic               o_dump_busy,
  output logic               o_dump_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [MEM_SZ-1:0] LAST_ADDR = '1;

  state_t             r_state;
  state_t             w_next_state;
  logic [MEM_SZ-1:0]  r_cnt;
  logic               r_dump_valid;
  logic [INST_SZ-1:0] r_dump_data;
  logic [MEM_SZ-1:0]  r_dump_addr;

  logic w_pipe_act;
  logic w_handshake;

  assign w_pipe_act  = i_mem_read_M | i_mem_write_M;
  assign w_handshake = r_dump_valid & i_dump_ready;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_mem_addr   = i_addr_M;
    o_mem_wdata  = i_wdata_M;

    if (w_pipe_act) begin
      o_mem_read  = i_mem_read_M;
      o_mem_write = i_mem_write_M;
    end else if (r_state == S_ISSUE) begin
      o_mem_read = 1'b1;
      o_mem_addr = r_cnt;
    end

    unique case (r_state)
      S_IDLE:    if (i_dump_start) w_next_state = S_ISSUE;
      S_ISSUE:   if (!w_pipe_act)  w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = S_HOLD;
      S_HOLD:    if (w_handshake)  w_next_state = (r_cnt == LAST_ADDR) ? S_DONE : S_ISSUE;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_dump_valid <= 1'b0;
      r_dump_data  <= '0;
      r_dump_addr  <= '0;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        S_IDLE: if (i_dump_start) r_cnt <= '0;
        // Read data for the word issued last cycle is on i_mem_rdata now.
        S_CAPTURE: begin
          r_dump_data  <= i_mem_rdata;
          r_dump_addr  <= r_cnt;
          r_dump_valid <= 1'b1;
        end
        S_HOLD: begin
          if (w_handshake) begin
            r_dump_valid <= 1'b0;
            if (r_cnt != LAST_ADDR) r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dump_valid = r_dump_valid;
  assign o_dump_data  = r_dump_data;
  assign o_dump_addr  = r_dump_addr;
  assign o_dump_busy  = (r_state != S_IDLE);
  assign o_dump_done  = (r_state == S_DONE);

endmodule
